// File: rtl/regbank_pkg.sv
// regbank_pkg
//   Shared types and helpers for the register-bank arbiter.
//   state_t : access FSM states (IDLE, ACCESS, DONE)
//   rr_pick : round-robin winner search over up to MAX_REQ requesters
package regbank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int MAX_REQ = 8;

    // Returns the first requester at or after ptr (wrapping modulo num_req).
    // The fixed-bound loop walks from the farthest candidate back to ptr so
    // the nearest active one is written last and wins.
    // If nothing is requesting, ptr is returned.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int                 num_req);
        logic [2:0] win;
        int         cand;
        win = ptr;
        for (int n = MAX_REQ - 1; n >= 0; n--) begin
            if (n < num_req) begin
                cand = (int'(ptr) + n) % num_req;
                if (req[cand]) begin
                    win = 3'(cand);
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/regbank_arbiter_if.sv
// regbank_arbiter_if
//   Bundles the SPI register port and the internal requester req/gnt port.
//   master : SPI slave + requesters (drive address/data/strobes, receive data/gnt)
//   slave  : the register bank arbiter
interface regbank_arbiter_if #(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 8,
    parameter int NUM_REQ  = 2
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    // SPI register port
    logic [ADDR_W-1:0]         spi_addr;
    logic [WIDTH-1:0]          spi_wdata;
    logic                      spi_wr_vld;
    logic [WIDTH-1:0]          spi_rdata;

    // Internal requester port
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]  req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [WIDTH-1:0]          rdata;
    logic                      rvalid;

    modport master (
        output spi_addr, spi_wdata, spi_wr_vld,
        output req, req_we, req_addr, req_wdata,
        input  spi_rdata, gnt, rdata, rvalid
    );

    modport slave (
        input  spi_addr, spi_wdata, spi_wr_vld,
        input  req, req_we, req_addr, req_wdata,
        output spi_rdata, gnt, rdata, rvalid
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter.
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    highest-priority index for this decision
//   grant out NUM_REQ  one-hot winner (all zero when no request)
//   idx   out IDX_W    winner index (equals ptr when no request)
module rr_arbiter
    import regbank_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [MAX_REQ-1:0] req_pad;
    logic [2:0]         pick;

    always_comb begin
        req_pad              = '0;
        req_pad[NUM_REQ-1:0] = req;
        pick                 = rr_pick(req_pad, 3'(ptr), NUM_REQ);
        idx                  = IDX_W'(pick);
        grant                = (|req) ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/regbank_arbiter.sv
// regbank_arbiter
//   Configuration register file shared between the SPI register slave and
//   NUM_REQ internal requesters. SPI writes are single-cycle and always win
//   the cycle; internal requests are served round-robin via req/gnt.
//
//   clk         in   system clock
//   rstb        in   synchronous active-low reset
//   ena         in   block enable; low freezes registers and the FSM
//   bus         slave modport of regbank_arbiter_if (SPI port + req/gnt port)
//   config_regs out  NUM_REGS*WIDTH flat register image, reg k at [k*WIDTH +: WIDTH]
//   busy        out  high while the FSM is outside IDLE
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 8,
    parameter int NUM_REQ  = 2
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      ena,
    regbank_arbiter_if.slave          bus,
    output logic [NUM_REGS*WIDTH-1:0] config_regs,
    output logic                      busy
);

    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int IDX_W  = $clog2(NUM_REQ);

    state_t             state;
    state_t             state_nxt;
    logic               latch_en;
    logic               access_en;

    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;

    // Attributes of the transaction being served, captured when it is picked
    logic [IDX_W-1:0]   win_idx;
    logic               win_we;
    logic [ADDR_W-1:0]  win_addr;
    logic [WIDTH-1:0]   win_wdata;

    logic [NUM_REQ-1:0] gnt_q;
    logic               rvalid_q;
    logic [WIDTH-1:0]   rdata_q;

    logic [WIDTH-1:0]   mem [NUM_REGS];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    function automatic logic [WIDTH-1:0] rd_mem(input logic [ADDR_W-1:0] a);
        return in_range(a) ? mem[a] : '0;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // FSM next state. A SPI strobe blocks both picking and performing an
    // internal access, so SPI and internal writes never share a cycle.
    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        access_en = 1'b0;
        case (state)
            IDLE: begin
                if (ena && (|arb_grant) && !bus.spi_wr_vld) begin
                    latch_en  = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (ena && !bus.spi_wr_vld) begin
                    access_en = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (ena) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Requester attributes are frozen here; later req-side changes are ignored.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            win_idx   <= arb_idx;
            win_we    <= bus.req_we[arb_idx];
            win_addr  <= bus.req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
            win_wdata <= bus.req_wdata[int'(arb_idx)*WIDTH +: WIDTH];
        end
    end

    // gnt/rvalid are set on the access edge so they show during DONE only.
    // The round-robin pointer moves past the winner at the same time.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            gnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rr_ptr   <= '0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= 1'b0;
            if (access_en) begin
                gnt_q    <= NUM_REQ'(1) << win_idx;
                rvalid_q <= !win_we;
                if (!win_we) begin
                    rdata_q <= rd_mem(win_addr);
                end
                rr_ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                mem[k] <= '0;
            end
        end else if (ena && bus.spi_wr_vld) begin
            if (in_range(bus.spi_addr)) begin
                mem[bus.spi_addr] <= bus.spi_wdata;
            end
        end else if (access_en && win_we && in_range(win_addr)) begin
            mem[win_addr] <= win_wdata;
        end
    end

    assign bus.spi_rdata = rd_mem(bus.spi_addr);
    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign busy          = (state != IDLE);

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_cfg
        assign config_regs[k*WIDTH +: WIDTH] = mem[k];
    end

endmodule

// File: tb/tb_regbank_arbiter.sv
// tb_regbank_arbiter
//   Directed scenarios followed by randomized traffic, all checked against a
//   transaction-level reference model of the register bank.
module tb_regbank_arbiter;

    localparam int NUM_REGS = 8;
    localparam int WIDTH    = 8;
    localparam int NUM_REQ  = 2;
    localparam int ADDR_W   = 3;

    logic                      clk  = 1'b0;
    logic                      rstb = 1'b0;
    logic                      ena  = 1'b0;
    logic [NUM_REGS*WIDTH-1:0] config_regs;
    logic                      busy;

    regbank_arbiter_if #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

    regbank_arbiter #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .bus         (bus),
        .config_regs (config_regs),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: register contents plus the one transaction in flight
    logic [WIDTH-1:0]   m_mem [NUM_REGS];
    bit                 m_txn;    // a request has been picked, not yet served
    bit                 m_cool;   // grant just issued; next edge cannot pick
    int                 m_ptr;    // requester with first priority next time
    int                 m_idx;
    int                 m_addr;
    bit                 m_we;
    logic [WIDTH-1:0]   m_wd;
    logic [WIDTH-1:0]   m_rdata;
    logic [NUM_REQ-1:0] e_gnt;
    bit                 e_rv;

    function automatic logic [WIDTH-1:0] m_read(input int a);
        return (a < NUM_REGS) ? m_mem[a] : '0;
    endfunction

    function automatic logic [63:0] m_image();
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < NUM_REGS; k++) v[k*WIDTH +: WIDTH] = m_mem[k];
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        e_gnt = '0;
        e_rv  = 1'b0;
        if (!rstb) begin
            for (int k = 0; k < NUM_REGS; k++) m_mem[k] = '0;
            m_txn   = 1'b0;
            m_cool  = 1'b0;
            m_ptr   = 0;
            m_rdata = '0;
            return;
        end
        if (!ena) return;
        if (bus.spi_wr_vld && int'(bus.spi_addr) < NUM_REGS)
            m_mem[bus.spi_addr] = bus.spi_wdata;
        if (m_txn) begin
            if (!bus.spi_wr_vld) begin
                e_gnt = NUM_REQ'(1) << m_idx;
                e_rv  = !m_we;
                if (m_we) begin
                    if (m_addr < NUM_REGS) m_mem[m_addr] = m_wd;
                end else begin
                    m_rdata = m_read(m_addr);
                end
                m_txn  = 1'b0;
                m_cool = 1'b1;
                m_ptr  = (m_idx + 1) % NUM_REQ;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (bus.req != '0 && !bus.spi_wr_vld) begin
            for (int n = 0; n < NUM_REQ; n++) begin
                int c;
                c = (m_ptr + n) % NUM_REQ;
                if (bus.req[c]) begin
                    m_idx = c;
                    break;
                end
            end
            m_we   = bus.req_we[m_idx];
            m_addr = int'(bus.req_addr[m_idx*ADDR_W +: ADDR_W]);
            m_wd   = bus.req_wdata[m_idx*WIDTH +: WIDTH];
            m_txn  = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        model_step();
        check("gnt", 64'(bus.gnt), 64'(e_gnt));
        check("rvalid", 64'(bus.rvalid), 64'(e_rv));
        check("rdata", 64'(bus.rdata), 64'(m_rdata));
        check("busy", 64'(busy), 64'(m_txn || m_cool));
        check("config_regs", config_regs, m_image());
    endtask

    task automatic spi_check();
        #1;
        check("spi_rdata", 64'(bus.spi_rdata), 64'(m_read(int'(bus.spi_addr))));
    endtask

    task automatic spi_wr(input int a, input logic [WIDTH-1:0] d);
        bus.spi_addr   = ADDR_W'(a);
        bus.spi_wdata  = d;
        bus.spi_wr_vld = 1'b1;
        tick();
        bus.spi_wr_vld = 1'b0;
    endtask

    task automatic present(input int i, input bit we, input int a, input logic [WIDTH-1:0] d);
        bus.req[i]                         = 1'b1;
        bus.req_we[i]                      = we;
        bus.req_addr[i*ADDR_W +: ADDR_W]   = ADDR_W'(a);
        bus.req_wdata[i*WIDTH +: WIDTH]    = d;
    endtask

    initial begin
        logic [NUM_REQ-1:0] exp_g;
        int                 n_gnt;

        bus.spi_addr   = '0;
        bus.spi_wdata  = '0;
        bus.spi_wr_vld = 1'b0;
        bus.req        = '0;
        bus.req_we     = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        ena            = 1'b1;
        rstb           = 1'b0;
        tick();
        tick();
        rstb = 1'b1;

        // Reset clears a previously written register
        spi_wr(3, 8'hA5);
        check("pre_reset_reg3", 64'(config_regs[31:24]), 64'hA5);
        rstb = 1'b0;
        tick();
        rstb = 1'b1;
        check("reset_cfg", config_regs, 64'h0);
        check("reset_gnt", 64'(bus.gnt), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);

        // SPI write and combinational read-back
        spi_wr(5, 8'h3C);
        check("spi_wr_reg5", 64'(config_regs[47:40]), 64'h3C);
        bus.spi_addr = 3'd5;
        #1;
        check("spi_rd_reg5", 64'(bus.spi_rdata), 64'h3C);

        // Internal read latency: picked at edge t, granted at edge t+1 output
        spi_wr(2, 8'h77);
        present(0, 1'b0, 2, 8'h00);
        tick();
        check("rd_lat_t", 64'(bus.gnt), 64'h0);
        tick();
        check("rd_lat_gnt", 64'(bus.gnt), 64'h1);
        check("rd_lat_rvalid", 64'(bus.rvalid), 64'h1);
        check("rd_lat_rdata", 64'(bus.rdata), 64'h77);
        bus.req = '0;
        tick();
        tick();

        // Round-robin with both requesters writing continuously
        present(0, 1'b1, 6, 8'h10);
        present(1, 1'b1, 7, 8'h20);
        exp_g = 2'b10;
        n_gnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.gnt != '0) begin
                n_gnt++;
                check("rr_order", 64'(bus.gnt), 64'(exp_g));
                exp_g = ~exp_g;
            end
        end
        check("rr_count", 64'(n_gnt), 64'd4);
        bus.req = '0;
        tick();
        tick();

        // SPI write to the same address stalls the internal write; internal wins last
        present(1, 1'b1, 4, 8'h11);
        tick();
        bus.spi_addr   = 3'd4;
        bus.spi_wdata  = 8'h22;
        bus.spi_wr_vld = 1'b1;
        tick();
        bus.spi_wr_vld = 1'b0;
        check("coll_stall_gnt", 64'(bus.gnt), 64'h0);
        check("coll_spi_val", 64'(config_regs[39:32]), 64'h22);
        tick();
        check("coll_gnt", 64'(bus.gnt), 64'h2);
        check("coll_final", 64'(config_regs[39:32]), 64'h11);
        bus.req = '0;
        tick();
        tick();

        // ena low during ACCESS drops the SPI strobe and holds the access
        present(0, 1'b1, 6, 8'h5A);
        tick();
        ena            = 1'b0;
        bus.spi_addr   = 3'd1;
        bus.spi_wdata  = 8'hFF;
        bus.spi_wr_vld = 1'b1;
        tick();
        check("ena_lo_gnt", 64'(bus.gnt), 64'h0);
        check("ena_lo_reg1", 64'(config_regs[15:8]), 64'h0);
        ena            = 1'b1;
        bus.spi_wr_vld = 1'b0;
        tick();
        check("ena_hi_gnt", 64'(bus.gnt), 64'h1);
        check("ena_hi_reg1", 64'(config_regs[15:8]), 64'h0);
        check("ena_hi_reg6", 64'(config_regs[55:48]), 64'h5A);
        bus.req = '0;
        tick();
        tick();

        // Randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.gnt[i]) begin
                    if ($urandom_range(1) == 1)
                        present(i, 1'($urandom_range(1)), $urandom_range(NUM_REGS-1), 8'($urandom));
                    else
                        bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(3) == 0) begin
                    present(i, 1'($urandom_range(1)), $urandom_range(NUM_REGS-1), 8'($urandom));
                end
            end
            bus.spi_wr_vld = ($urandom_range(9) < 3);
            bus.spi_addr   = ADDR_W'($urandom_range(NUM_REGS-1));
            bus.spi_wdata  = 8'($urandom);
            ena            = ($urandom_range(19) != 0);
            rstb           = ($urandom_range(199) != 0);
            spi_check();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
